// File: rtl/sr_control_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/branch/jump over one req/ack memory port.
// Optional macro SR_CONTROL_FSM_TRAP_EN: illegal instructions and watchdog expiry park in TRAP.
module sr_control_fsm #(
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            cmdOp,
  input  logic [2:0]            cmdF3,
  input  logic [6:0]            cmdF7,
  input  logic                  aluZero,
  input  logic                  memAck,
  output logic                  memReq,
  output logic                  memWe,
  output logic                  memAddrSrc,
  output logic                  irWrite,
  output logic                  pcWrite,
  output logic [1:0]            pcSrc,
  output logic                  regWrite,
  output logic [1:0]            wdSrc,
  output logic                  aluSrcA,
  output logic                  aluSrc,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  invalid_instr,
  output logic                  memTimeout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                         OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                         OP_LOAD = 7'h03, OP_STORE = 7'h23;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0), ALU_SUB = ALU_CTRL_W'(1),
    ALU_SLL = ALU_CTRL_W'(2), ALU_SLT = ALU_CTRL_W'(3), ALU_SLTU = ALU_CTRL_W'(4),
    ALU_XOR = ALU_CTRL_W'(5), ALU_SRL = ALU_CTRL_W'(6), ALU_SRA = ALU_CTRL_W'(7),
    ALU_OR = ALU_CTRL_W'(8), ALU_AND = ALU_CTRL_W'(9);

`ifdef SR_CONTROL_FSM_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam int       CW      = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam logic     WD_EN   = (TIMEOUT_W > 0);
  localparam int       EXP_INT = (TIMEOUT_W > 0) ? (1 << TIMEOUT_W) - 2 : 0;
  localparam [CW-1:0]  EXP_CNT = CW'(EXP_INT);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_q, timeout_q;
  logic            illegal, mem_req, expire, taken;
  logic [ALU_CTRL_W-1:0] alu_ri;

  always_comb begin
    illegal = 1'b1;
    case (cmdOp)
      OP_R:     illegal = !(cmdF7 == 7'h00 ||
                            (cmdF7 == 7'h20 && (cmdF3 == 3'b000 || cmdF3 == 3'b101)));
      OP_I:     illegal = (cmdF3 == 3'b001 && cmdF7 != 7'h00) ||
                          (cmdF3 == 3'b101 && cmdF7 != 7'h00 && cmdF7 != 7'h20);
      OP_LUI, OP_AUIPC, OP_JAL: illegal = 1'b0;
      OP_BR:    illegal = (cmdF3 == 3'b010 || cmdF3 == 3'b011);
      OP_JALR:  illegal = (cmdF3 != 3'b000);
      OP_LOAD:  illegal = (cmdF3 == 3'b011 || cmdF3 == 3'b110 || cmdF3 == 3'b111);
      OP_STORE: illegal = (cmdF3 > 3'b010);
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_ri = ALU_ADD;
    case (cmdF3)
      3'b000:  alu_ri = (cmdOp == OP_R && cmdF7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ri = ALU_SLL;
      3'b010:  alu_ri = ALU_SLT;
      3'b011:  alu_ri = ALU_SLTU;
      3'b100:  alu_ri = ALU_XOR;
      3'b101:  alu_ri = cmdF7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ri = ALU_OR;
      default: alu_ri = ALU_AND;
    endcase
  end

  // Less-than branches compute SLT/SLTU, so a non-zero result means "less".
  always_comb begin
    taken = 1'b0;
    case (cmdF3)
      3'b000:         taken = aluZero;
      3'b001:         taken = !aluZero;
      3'b100, 3'b110: taken = !aluZero;
      default:        taken = aluZero;
    endcase
  end

  assign mem_req = (state_q == S_FETCH && !abort_q) || state_q == S_MEM;
  assign expire  = WD_EN && mem_req && !memAck && cnt_q == EXP_CNT;

  always_comb begin
    state_d       = state_q;
    memReq        = 1'b0;
    memWe         = 1'b0;
    memAddrSrc    = 1'b0;
    irWrite       = 1'b0;
    pcWrite       = 1'b0;
    pcSrc         = 2'd0;
    regWrite      = 1'b0;
    wdSrc         = 2'd0;
    aluSrcA       = 1'b0;
    aluSrc        = 1'b0;
    aluControl    = ALU_ADD;
    invalid_instr = 1'b0;
    busy          = (state_q != S_RESET);
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        memReq  = mem_req;
        irWrite = mem_req && memAck;
        if (mem_req && memAck) state_d = S_DECODE;
        else if (expire)       state_d = TRAP_EN ? S_TRAP : S_FETCH;
      end
      S_DECODE: begin
        invalid_instr = illegal;
        if (illegal) state_d = TRAP_EN ? S_TRAP : S_EXEC;
        else case (cmdOp)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL, OP_JALR:   state_d = S_JUMP;
          default:           state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        pcWrite = 1'b1;
        if (!illegal) begin
          regWrite   = 1'b1;
          wdSrc      = (cmdOp == OP_LUI) ? 2'd1 : 2'd0;
          aluSrcA    = (cmdOp == OP_AUIPC);
          aluSrc     = (cmdOp != OP_R);
          aluControl = (cmdOp == OP_R || cmdOp == OP_I) ? alu_ri : ALU_ADD;
        end
        state_d = S_FETCH;
      end
      S_MEM: begin
        memReq     = 1'b1;
        memAddrSrc = 1'b1;
        memWe      = (cmdOp == OP_STORE);
        aluSrc     = 1'b1;
        if (memAck) begin
          pcWrite  = 1'b1;
          regWrite = (cmdOp == OP_LOAD);
          wdSrc    = (cmdOp == OP_LOAD) ? 2'd2 : 2'd0;
          state_d  = S_FETCH;
        end else if (expire) begin
          pcWrite = !TRAP_EN;
          state_d = TRAP_EN ? S_TRAP : S_FETCH;
        end
      end
      S_BRANCH: begin
        aluControl = (cmdF3[2:1] == 2'b00) ? ALU_SUB : (cmdF3[1] ? ALU_SLTU : ALU_SLT);
        pcWrite    = 1'b1;
        pcSrc      = taken ? 2'd1 : 2'd0;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        regWrite = 1'b1;
        wdSrc    = 2'd3;
        pcWrite  = 1'b1;
        if (cmdOp == OP_JALR) begin
          pcSrc  = 2'd3;
          aluSrc = 1'b1;
        end else begin
          pcSrc  = 2'd2;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Any expiry clears the count; the following FETCH cycle idles with memReq low.
  always_comb begin
    if (state_d != state_q || expire) cnt_d = '0;
    else if (mem_req && !memAck)      cnt_d = cnt_q + CW'(1);
    else                              cnt_d = cnt_q;
  end

  assign memTimeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      abort_q   <= expire;
      timeout_q <= timeout_q | expire;
    end
  end

endmodule

// File: tb/tb_sr_control_fsm.sv
// Directed self-checking bench for sr_control_fsm (TIMEOUT_W=3), both trap build options.
module tb_sr_control_fsm;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] cmdOp = 7'h00, cmdF7 = 7'h00;
  logic [2:0] cmdF3 = 3'd0;
  logic aluZero = 1'b0, memAck = 1'b0;
  logic memReq, memWe, memAddrSrc, irWrite, pcWrite, regWrite, aluSrcA, aluSrc;
  logic invalid_instr, memTimeout, busy;
  logic [1:0] pcSrc, wdSrc;
  logic [3:0] aluControl;
  int n_cmp = 0, n_err = 0;

  sr_control_fsm #(.ALU_CTRL_W(4), .TIMEOUT_W(3)) dut (
    .clk(clk), .rst(rst), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
    .aluZero(aluZero), .memAck(memAck), .memReq(memReq), .memWe(memWe),
    .memAddrSrc(memAddrSrc), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .regWrite(regWrite), .wdSrc(wdSrc), .aluSrcA(aluSrcA), .aluSrc(aluSrc),
    .aluControl(aluControl), .invalid_instr(invalid_instr), .memTimeout(memTimeout),
    .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; memAck = 1'b0; aluZero = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Starts in FETCH, returns at the DECODE cycle.
  task automatic fetch_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cmdOp = op; cmdF3 = f3; cmdF7 = f7; memAck = 1'b1;
    tick();
    memAck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if (memReq !== 1'b0) begin n_err++; $display("FAIL reset_memReq got %0b exp 0", memReq); end
    n_cmp++; if (memTimeout !== 1'b0) begin n_err++; $display("FAIL reset_memTimeout got %0b exp 0", memTimeout); end
    rst = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy got %0b exp 0", busy); end
    tick();
    n_cmp++; if ({busy, memReq, memAddrSrc} !== 3'b110) begin n_err++; $display("FAIL first_fetch got %b exp 110", {busy, memReq, memAddrSrc}); end
  endtask

  task automatic test_alu();
    logic [6:0] op_t [5] = '{7'h33, 7'h13, 7'h13, 7'h37, 7'h17};
    logic [2:0] f3_t [5] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd0};
    logic [6:0] f7_t [5] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00};
    logic [3:0] al_t [5] = '{4'd1, 4'd7, 4'd9, 4'd0, 4'd0};
    logic [1:0] wd_t [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    logic       sa_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       sb_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cmdOp = 7'h33; cmdF3 = 3'd0; cmdF7 = 7'h00; memAck = 1'b1; #1;
    n_cmp++; if ({memReq, irWrite, regWrite} !== 3'b110) begin n_err++; $display("FAIL add_fetch got %b exp 110", {memReq, irWrite, regWrite}); end
    tick(); memAck = 1'b0; #1;
    n_cmp++; if ({memReq, regWrite, pcWrite, invalid_instr} !== 4'b0000) begin n_err++; $display("FAIL add_decode got %b exp 0000", {memReq, regWrite, pcWrite, invalid_instr}); end
    tick(); #1;
    n_cmp++; if ({regWrite, pcWrite, pcSrc, wdSrc, aluSrc, aluControl} !== {1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 4'd0})
      begin n_err++; $display("FAIL add_exec got %b exp 11000000000", {regWrite, pcWrite, pcSrc, wdSrc, aluSrc, aluControl}); end
    tick(); #1;
    n_cmp++; if ({memReq, regWrite, pcWrite} !== 3'b100) begin n_err++; $display("FAIL add_refetch got %b exp 100", {memReq, regWrite, pcWrite}); end
    for (int i = 0; i < 5; i++) begin
      fetch_instr(op_t[i], f3_t[i], f7_t[i]);
      tick(); #1;
      n_cmp++; if ({regWrite, pcWrite, wdSrc, aluSrcA} !== {2'b11, wd_t[i], sa_t[i]})
        begin n_err++; $display("FAIL exec_ctl[%0d] got %b exp %b", i, {regWrite, pcWrite, wdSrc, aluSrcA}, {2'b11, wd_t[i], sa_t[i]}); end
      if (op_t[i] != 7'h37) begin
        n_cmp++; if ({aluSrc, aluControl} !== {sb_t[i], al_t[i]})
          begin n_err++; $display("FAIL exec_alu[%0d] got %b exp %b", i, {aluSrc, aluControl}, {sb_t[i], al_t[i]}); end
      end
      tick();
    end
  endtask

  task automatic test_load_store();
    int req_cycles = 0;
    fetch_instr(7'h03, 3'd2, 7'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (memReq === 1'b1) req_cycles++;
      n_cmp++; if ({memAddrSrc, memWe, regWrite, pcWrite} !== 4'b1000)
        begin n_err++; $display("FAIL lw_wait[%0d] got %b exp 1000", i, {memAddrSrc, memWe, regWrite, pcWrite}); end
      tick();
    end
    memAck = 1'b1; #1;
    if (memReq === 1'b1) req_cycles++;
    n_cmp++; if ({regWrite, wdSrc, pcWrite, pcSrc, aluSrc, aluControl} !== {1'b1, 2'd2, 1'b1, 2'd0, 1'b1, 4'd0})
      begin n_err++; $display("FAIL lw_ack got %b exp 1101001 0000", {regWrite, wdSrc, pcWrite, pcSrc, aluSrc, aluControl}); end
    n_cmp++; if (req_cycles !== 6) begin n_err++; $display("FAIL lw_req_cycles got %0d exp 6", req_cycles); end
    tick(); memAck = 1'b0; #1;
    n_cmp++; if ({memReq, regWrite, memTimeout} !== 3'b100) begin n_err++; $display("FAIL lw_next got %b exp 100", {memReq, regWrite, memTimeout}); end
    fetch_instr(7'h23, 3'd2, 7'h00);
    tick(); memAck = 1'b1; #1;
    n_cmp++; if ({memReq, memWe, memAddrSrc, regWrite, pcWrite} !== 5'b11101)
      begin n_err++; $display("FAIL sw_ack got %b exp 11101", {memReq, memWe, memAddrSrc, regWrite, pcWrite}); end
    tick(); memAck = 1'b0;
  endtask

  task automatic test_branch();
    logic [2:0] f3_t [4] = '{3'd6, 3'd5, 3'd0, 3'd1};
    logic       z_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] pc_t [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic [3:0] al_t [4] = '{4'd4, 4'd3, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) begin
      fetch_instr(7'h63, f3_t[i], 7'h00);
      tick(); aluZero = z_t[i]; #1;
      n_cmp++; if ({pcWrite, pcSrc, regWrite, aluControl} !== {1'b1, pc_t[i], 1'b0, al_t[i]})
        begin n_err++; $display("FAIL branch[%0d] got %b exp %b", i, {pcWrite, pcSrc, regWrite, aluControl}, {1'b1, pc_t[i], 1'b0, al_t[i]}); end
      tick(); aluZero = 1'b0;
    end
  endtask

  task automatic test_jump();
    fetch_instr(7'h67, 3'd0, 7'h00);
    tick(); #1;
    n_cmp++; if ({regWrite, wdSrc, pcWrite, pcSrc, aluSrc, aluControl} !== {1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 4'd0})
      begin n_err++; $display("FAIL jalr got %b exp 1111111 0000", {regWrite, wdSrc, pcWrite, pcSrc, aluSrc, aluControl}); end
    tick();
    fetch_instr(7'h6F, 3'd0, 7'h00);
    tick(); #1;
    n_cmp++; if ({regWrite, wdSrc, pcWrite, pcSrc} !== {1'b1, 2'd3, 1'b1, 2'd2})
      begin n_err++; $display("FAIL jal got %b exp 111110", {regWrite, wdSrc, pcWrite, pcSrc}); end
    tick();
  endtask

  task automatic test_invalid();
    fetch_instr(7'h7F, 3'd0, 7'h00); #1;
    n_cmp++; if ({invalid_instr, regWrite, pcWrite} !== 3'b100) begin n_err++; $display("FAIL inv_decode got %b exp 100", {invalid_instr, regWrite, pcWrite}); end
    tick(); #1;
`ifdef SR_CONTROL_FSM_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({busy, memReq, invalid_instr, pcWrite, regWrite} !== 5'b10000)
        begin n_err++; $display("FAIL trap_hold[%0d] got %b exp 10000", i, {busy, memReq, invalid_instr, pcWrite, regWrite}); end
      tick();
    end
    apply_reset();
`else
    n_cmp++; if ({invalid_instr, regWrite, pcWrite, pcSrc} !== 5'b00100) begin n_err++; $display("FAIL inv_nop got %b exp 00100", {invalid_instr, regWrite, pcWrite, pcSrc}); end
    tick(); #1;
    n_cmp++; if (memReq !== 1'b1) begin n_err++; $display("FAIL inv_refetch got %b exp 1", memReq); end
    fetch_instr(7'h33, 3'd0, 7'h01); #1;
    n_cmp++; if (invalid_instr !== 1'b1) begin n_err++; $display("FAIL inv_f7 got %b exp 1", invalid_instr); end
    tick(); tick();
`endif
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      #1;
      n_cmp++; if ({memReq, memTimeout} !== 2'b10) begin n_err++; $display("FAIL wd_wait[%0d] got %b exp 10", i, {memReq, memTimeout}); end
      tick();
    end
    #1;
    n_cmp++; if ({memTimeout, memReq, busy} !== 3'b101) begin n_err++; $display("FAIL wd_fire got %b exp 101", {memTimeout, memReq, busy}); end
    tick(); #1;
`ifdef SR_CONTROL_FSM_TRAP_EN
    n_cmp++; if ({memTimeout, memReq, busy} !== 3'b101) begin n_err++; $display("FAIL wd_trap got %b exp 101", {memTimeout, memReq, busy}); end
`else
    n_cmp++; if ({memTimeout, memReq} !== 2'b11) begin n_err++; $display("FAIL wd_refetch got %b exp 11", {memTimeout, memReq}); end
    apply_reset();
    fetch_instr(7'h03, 3'd2, 7'h00);
    tick();
    repeat (6) tick();
    #1;
    n_cmp++; if ({pcWrite, pcSrc, regWrite} !== 4'b1000) begin n_err++; $display("FAIL wd_mem_skip got %b exp 1000", {pcWrite, pcSrc, regWrite}); end
    tick(); #1;
    n_cmp++; if ({memReq, memTimeout, pcWrite} !== 3'b010) begin n_err++; $display("FAIL wd_mem_abort got %b exp 010", {memReq, memTimeout, pcWrite}); end
`endif
    apply_reset();
    repeat (6) tick();
    cmdOp = 7'h33; cmdF3 = 3'd0; cmdF7 = 7'h00; memAck = 1'b1; #1;
    n_cmp++; if (irWrite !== 1'b1) begin n_err++; $display("FAIL ack_at_expiry got %b exp 1", irWrite); end
    tick(); memAck = 1'b0; #1;
    n_cmp++; if ({memTimeout, busy} !== 2'b01) begin n_err++; $display("FAIL ack_at_expiry_sticky got %b exp 01", {memTimeout, busy}); end
  endtask

  task automatic test_rst_mid_mem();
    apply_reset();
    fetch_instr(7'h03, 3'd2, 7'h00);
    tick(); #1;
    n_cmp++; if (memReq !== 1'b1) begin n_err++; $display("FAIL mid_mem_req got %b exp 1", memReq); end
    rst = 1'b1; #1;
    n_cmp++; if ({memReq, busy, regWrite} !== 3'b000) begin n_err++; $display("FAIL mid_mem_rst got %b exp 000", {memReq, busy, regWrite}); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump();
    test_invalid();
    test_timeout();
    test_rst_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
